// File: rtl/eth_mac_1g_tx.sv
// GMII 1G MAC transmit: preamble, SFD, payload, optional pad, FCS, IFG; byte stream in, GMII out.
// Latency: 1 cycle from accepted byte to tx_data; first payload byte 8 cycles after first 0x55.
// Backpressure: s_ready high only in DATA/DRAIN; a missing byte mid-frame aborts with tx_er.
// Optional padding to MIN_PAYLOAD is compiled in with `define ETH_TX_PAD_EN.
module eth_mac_1g_tx #(
    parameter int IFG_CYCLES  = 12,
    parameter int MIN_PAYLOAD = 60,
    parameter int MAX_PAYLOAD = 1514
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_abort
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SFD   = 3'd2,
        S_DATA  = 3'd3,
`ifdef ETH_TX_PAD_EN
        S_PAD   = 3'd4,
`endif
        S_FCS   = 3'd5,
        S_IFG   = 3'd6,
        S_DRAIN = 3'd7
    } state_t;

    // The IDLE cycle before the next preamble is itself one idle wire cycle,
    // so the IFG state only has to cover the remaining IFG_CYCLES-1.
    localparam logic [15:0] IFG_LAST = (IFG_CYCLES > 1) ? 16'(IFG_CYCLES - 2) : 16'd0;
    localparam state_t      POST_FCS = (IFG_CYCLES > 1) ? S_IFG : S_IDLE;
    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
`ifdef ETH_TX_PAD_EN
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
`endif

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [10:0] len, len_n, len_inc;
    logic [31:0] crc, crc_n;
    logic [7:0]  data_n;
    logic        en_n, er_n, done_n, abort_n;
    logic        hs;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign hs      = s_valid && s_ready;
    assign len_inc = len + 11'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        crc_n   = crc;
        data_n  = 8'h00;
        en_n    = 1'b0;
        er_n    = 1'b0;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_valid) begin
                    state_n = S_PRE;
                    cnt_n   = 16'd0;
                end
            end
            S_PRE: begin
                en_n   = 1'b1;
                data_n = 8'h55;
                if (cnt == 16'd6) begin
                    state_n = S_SFD;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_SFD: begin
                en_n    = 1'b1;
                data_n  = 8'hD5;
                crc_n   = 32'hFFFFFFFF;
                len_n   = 11'd0;
                state_n = S_DATA;
            end
            S_DATA: begin
                en_n = 1'b1;
                if (hs && (s_last || len_inc != MAX_LEN)) begin
                    data_n = s_data;
                    crc_n  = crc_byte(crc, s_data);
                    len_n  = len_inc;
                    if (s_last) begin
                        cnt_n   = 16'd0;
                        state_n = S_FCS;
`ifdef ETH_TX_PAD_EN
                        if (len_inc < MIN_LEN) state_n = S_PAD;
`endif
                    end
                end else begin
                    // Underflow or oversize: poison the frame on the wire and drop the rest.
                    er_n    = 1'b1;
                    abort_n = 1'b1;
                    state_n = S_DRAIN;
                end
            end
`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                en_n  = 1'b1;
                crc_n = crc_byte(crc, 8'h00);
                len_n = len_inc;
                if (len_inc >= MIN_LEN) begin
                    state_n = S_FCS;
                    cnt_n   = 16'd0;
                end
            end
`endif
            S_FCS: begin
                en_n = 1'b1;
                case (cnt[1:0])
                    2'd0:    data_n = ~crc[7:0];
                    2'd1:    data_n = ~crc[15:8];
                    2'd2:    data_n = ~crc[23:16];
                    default: data_n = ~crc[31:24];
                endcase
                if (cnt[1:0] == 2'd3) begin
                    done_n  = 1'b1;
                    state_n = POST_FCS;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_IFG: begin
                if (cnt >= IFG_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_DRAIN: begin
                if (hs && s_last) begin
                    state_n = POST_FCS;
                    cnt_n   = 16'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            len         <= 11'd0;
            crc         <= 32'hFFFFFFFF;
            tx_data     <= 8'h00;
            tx_en       <= 1'b0;
            tx_er       <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            len         <= len_n;
            crc         <= crc_n;
            tx_data     <= data_n;
            tx_en       <= en_n;
            tx_er       <= er_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
            s_ready     <= (state_n == S_DATA) || (state_n == S_DRAIN);
            busy        <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_eth_mac_1g_tx.sv
// Bench for eth_mac_1g_tx: directed table, back-to-back gap, random frames with aborts, reset mid-preamble.
module tb_eth_mac_1g_tx;

    typedef logic [7:0] byte_q_t[$];

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif
    localparam int MIN_P = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid, s_last;
    logic       s_ready;
    logic [7:0] tx_data;
    logic       tx_en, tx_er, busy, frame_done, frame_abort;

    eth_mac_1g_tx #(.IFG_CYCLES(12), .MIN_PAYLOAD(MIN_P), .MAX_PAYLOAD(1514)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er), .busy(busy),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #4 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Expected wire: {end_marker, frame_done, frame_abort, tx_er, tx_data}
    logic [11:0] exp_w[$];
    int          len_q[$];
    int          gap_q[$];
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain MSB-first CRC-32 over bit-reversed bytes; result reflected and complemented.
    function automatic logic [31:0] ref_fcs(input byte_q_t b);
        logic [31:0] c, r;
        logic        top;
        c = 32'hFFFFFFFF;
        foreach (b[j]) begin
            for (int k = 0; k < 8; k++) begin
                top = c[31] ^ b[j][k];
                c   = c << 1;
                if (top) c = c ^ 32'h04C11DB7;
            end
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return ~r;
    endfunction

    task automatic model_frame(input byte_q_t p, input int stall_at, input bit use_const,
                               input logic [31:0] cfcs, output int en_cycles);
        byte_q_t     body;
        logic [31:0] f;
        en_cycles = 0;
        for (int k = 0; k < 7; k++) begin exp_w.push_back({4'b0000, 8'h55}); en_cycles++; end
        exp_w.push_back({4'b0000, 8'hD5}); en_cycles++;
        if (stall_at > 0) begin
            for (int k = 0; k < stall_at; k++) begin exp_w.push_back({4'b0000, p[k]}); en_cycles++; end
            exp_w.push_back({4'b0011, 8'h00}); en_cycles++;
        end else begin
            body = p;
            if (PAD_ON) while (body.size() < MIN_P) body.push_back(8'h00);
            f = use_const ? cfcs : ref_fcs(body);
            foreach (body[k]) begin exp_w.push_back({4'b0000, body[k]}); en_cycles++; end
            for (int k = 0; k < 4; k++) begin
                exp_w.push_back({1'b0, (k == 3), 2'b00, f[8*k +: 8]}); en_cycles++;
            end
        end
        exp_w.push_back(12'h800);
    endtask

    // Called at a negedge; s_ready is stable there and governs the next posedge.
    task automatic drive_frame(input byte_q_t p, input int stall_at);
        int i, t;
        bit hs, stalled;
        i = 0; t = 0; stalled = 1'b0;
        while (i < p.size() && t < 4000) begin
            if (i == stall_at && !stalled) begin
                s_valid = 1'b0;
                stalled = 1'b1;
            end else begin
                s_valid = 1'b1;
                s_data  = p[i];
                s_last  = (i == p.size() - 1);
            end
            hs = s_valid && s_ready;
            @(negedge clk); t++;
            if (hs) i++;
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        chk("drive_timeout", (t >= 4000), 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_w.size() != 0 || busy) && t < 4000) begin
            @(negedge clk); t++;
        end
        chk("idle_timeout", (t >= 4000), 0);
    endtask

    // Wire monitor
    initial begin
        bit          was_en;
        int          run, idle_run;
        logic [11:0] e;
        was_en = 0; run = 0; idle_run = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                was_en = 0; run = 0; idle_run = 0;
            end else if (tx_en) begin
                if (!was_en) begin gap_q.push_back(idle_run); idle_run = 0; end
                if (exp_w.size() == 0) chk("unexpected_tx", {23'd0, tx_er, tx_data}, 32'hFFFF_FFFF);
                else begin
                    e = exp_w.pop_front();
                    chk("wire", {20'd0, 1'b0, frame_done, frame_abort, tx_er, tx_data}, {20'd0, e});
                end
                run++; was_en = 1;
            end else begin
                if (was_en) begin
                    if (exp_w.size() == 0) chk("end_marker", 0, 12'h800);
                    else chk("end_marker", {20'd0, exp_w.pop_front()}, 12'h800);
                    len_q.push_back(run); run = 0;
                end
                was_en = 0;
                idle_run++;
                chk("idle_wire", {20'd0, frame_done, frame_abort, tx_er, tx_data}, 0);
            end
        end
    end

    typedef struct {
        int          len;
        int          kind;
        int          stall_at;
        bit          use_const;
        logic [31:0] cfcs;
        int          en_cycles;
    } vec_t;

    function automatic byte_q_t make_payload(input int len, input int kind);
        byte_q_t p;
        for (int k = 0; k < len; k++) begin
            case (kind)
                0:       p.push_back(8'(8'h31 + k));
                1:       p.push_back(8'(k));
                default: p.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        return p;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1);
    end

    initial begin
        vec_t    vecs[6];
        byte_q_t p, p2;
        int      ec, ec2, tx_seen, t;

        vecs[0] = '{9,  0, -1, !PAD_ON, 32'hCBF43926, PAD_ON ? 72 : 21};
        vecs[1] = '{60, 1, -1, 1'b0, 32'h0, 72};
        vecs[2] = '{14, 1, -1, 1'b0, 32'h0, PAD_ON ? 72 : 26};
        vecs[3] = '{40, 1, 20, 1'b0, 32'h0, 29};
        vecs[4] = '{1,  2, -1, 1'b0, 32'h0, PAD_ON ? 72 : 13};
        vecs[5] = '{61, 2, -1, 1'b0, 32'h0, 73};

        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {17'd0, tx_en, tx_er, s_ready, busy, frame_done, frame_abort, tx_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        foreach (vecs[v]) begin
            p = make_payload(vecs[v].len, vecs[v].kind);
            model_frame(p, vecs[v].stall_at, vecs[v].use_const, vecs[v].cfcs, ec);
            chk("model_en_cycles", ec, vecs[v].en_cycles);
            drive_frame(p, vecs[v].stall_at);
            wait_idle();
            if (len_q.size() == 0) chk("frame_seen", 0, 1);
            else chk("tx_en_cycles", len_q[$], vecs[v].en_cycles);
        end

        // Back-to-back frames with s_valid held across the boundary.
        p  = make_payload(20, 2);
        p2 = make_payload(30, 2);
        model_frame(p, -1, 1'b0, 32'h0, ec);
        model_frame(p2, -1, 1'b0, 32'h0, ec2);
        drive_frame(p, -1);
        drive_frame(p2, -1);
        wait_idle();
        if (gap_q.size() == 0) chk("gap_seen", 0, 1);
        else chk("ifg_gap", gap_q[$], 12);

        // Random frames, some aborted by a one-cycle s_valid drop.
        repeat (24) begin
            int len, st;
            len = $urandom_range(1, 100);
            st  = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
            p   = make_payload(len, 2);
            model_frame(p, st, 1'b0, 32'h0, ec);
            drive_frame(p, st);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of the preamble.
        mon_en = 1'b0;
        s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
        t = 0;
        while (!tx_en && t < 50) begin @(negedge clk); t++; end
        chk("pre_start_timeout", (t >= 50), 0);
        @(negedge clk);
        chk("busy_in_pre", {tx_en, busy, tx_data}, {1'b1, 1'b1, 8'h55});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {20'd0, tx_en, tx_er, s_ready, busy, tx_data}, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_w.delete();
        tx_seen = 0;
        repeat (20) begin @(negedge clk); if (tx_en) tx_seen++; end
        chk("no_resume", tx_seen, 0);

        mon_en = 1'b1;
        p = make_payload(9, 0);
        model_frame(p, -1, !PAD_ON, 32'hCBF43926, ec);
        drive_frame(p, -1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
